// File: rtl/apb_arbiter2_if.sv
// apb_arbiter2_if: one APB link (select, enable, direction, address, write
// data, read data, ready, error).
//   master modport: the side that issues transfers (drives psel/penable/
//                   pwrite/paddr/pwdata, receives prdata/pready/pslverr)
//   slave modport : the side that answers transfers
// Parameters: AW address width, DW data width.
interface apb_arbiter2_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_arbiter2.sv
// apb_arbiter2: round-robin arbiter sharing one APB slave between two
// APB masters, with an optional ACCESS-phase watchdog.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   m0   : master 0 link (slave modport: arbiter answers m0)
//   m1   : master 1 link (slave modport: arbiter answers m1)
//   s    : shared slave link (master modport: arbiter drives the slave)
//   gnt  : currently / last granted master index (debug)
// Parameters: AW address width, DW data width, TIMEOUT ACCESS cycles before
// a forced error completion (0 = disabled), TW timeout counter width.
module apb_arbiter2 #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 0,
  parameter int TW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  apb_arbiter2_if.slave         m0,
  apb_arbiter2_if.slave         m1,
  apb_arbiter2_if.master        s,
  output logic                  gnt
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT > 0);
  // Counter value seen in the last allowed ACCESS cycle (counter starts at 0).
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_n;
  logic          gnt_n;
  logic [TW-1:0] cnt, cnt_n;

  logic done_ok;
  logic tmo;
  logic done;
  logic other_req;

  // penable is not used for arbitration; slave-side pslverr is not forwarded.
  logic unused;
  assign unused = ^{m0.penable, m1.penable, s.pslverr};

  // s_pready only counts in ACCESS, so a stale ready held into SETUP is ignored.
  assign done_ok   = (state == ACCESS) && s.pready;
  assign tmo       = TMO_EN && (state == ACCESS) && !s.pready && (cnt == TMO_LAST);
  assign done      = done_ok || tmo;
  assign other_req = gnt ? m0.psel : m1.psel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    cnt_n   = '0;
    case (state)
      IDLE: begin
        if (m0.psel && m1.psel) begin
          gnt_n   = ~gnt;
          state_n = SETUP;
        end else if (m0.psel) begin
          gnt_n   = 1'b0;
          state_n = SETUP;
        end else if (m1.psel) begin
          gnt_n   = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (done) begin
          // The just-served master's psel is not looked at here.
          if (other_req) begin
            gnt_n   = ~gnt;
            state_n = SETUP;
          end else begin
            state_n = IDLE;
          end
        end else if (TMO_EN) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Slave side: phase strobes from registered state, payload follows gnt.
  assign s.psel    = (state != IDLE);
  assign s.penable = (state == ACCESS);
  assign s.pwrite  = gnt ? m1.pwrite : m0.pwrite;
  assign s.paddr   = gnt ? m1.paddr  : m0.paddr;
  assign s.pwdata  = gnt ? m1.pwdata : m0.pwdata;

  // Master side: completion goes to the granted master only. Gating with rst
  // abandons a transfer whose ready coincides with the reset cycle.
  assign m0.pready  = !rst && done && !gnt;
  assign m0.pslverr = !rst && tmo && !gnt;
  assign m0.prdata  = (!rst && done_ok && !gnt) ? s.prdata : '0;

  assign m1.pready  = !rst && done && gnt;
  assign m1.pslverr = !rst && tmo && gnt;
  assign m1.prdata  = (!rst && done_ok && gnt) ? s.prdata : '0;

endmodule

// File: tb/tb_apb_arbiter2.sv
module tb_apb_arbiter2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk;
  logic rst;
  logic gnt;

  apb_arbiter2_if #(.AW(AW), .DW(DW)) m0_if ();
  apb_arbiter2_if #(.AW(AW), .DW(DW)) m1_if ();
  apb_arbiter2_if #(.AW(AW), .DW(DW)) s_if ();

  apb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if),
    .gnt (gnt)
  );

  typedef struct {
    bit            mst;
    logic [DW-1:0] rdata;
    bit            err;
    logic [AW-1:0] addr;
    bit            wr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Slave model knobs.
  int            slv_wait  = 1;
  bit            slv_stale = 1'b0;
  logic [DW-1:0] slv_rdata = '0;

  assign s_if.prdata  = slv_rdata;
  assign s_if.pslverr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // Registered-ready slave: raises pready after slv_wait low ACCESS cycles,
  // optionally holding it one extra cycle (stale ready).
  initial begin : slave_model
    bit act, rdy, r, hold;
    int acc;
    s_if.pready = 1'b0;
    hold = 1'b0;
    acc  = 0;
    forever begin
      @(negedge clk);
      act = (s_if.psel === 1'b1) && (s_if.penable === 1'b1);
      rdy = s_if.pready;
      r   = rst;
      @(posedge clk);
      #1;
      if (r) begin
        s_if.pready = 1'b0; acc = 0; hold = 1'b0;
      end else if (act && !rdy) begin
        if (acc + 1 >= slv_wait) begin
          s_if.pready = 1'b1; acc = 0; hold = slv_stale;
        end else begin
          acc++;
        end
      end else if (rdy && hold) begin
        hold = 1'b0;
      end else begin
        s_if.pready = 1'b0;
        if (!act) acc = 0;
      end
    end
  end

  // Scoreboard: every master completion pops one expected transfer.
  always @(negedge clk) begin : monitor
    exp_t          e;
    bit            am;
    logic [DW-1:0] got_rd, oth_rd;
    logic          got_err, oth_err;
    if (m0_if.pready === 1'b1 || m1_if.pready === 1'b1) begin
      vectors++;
      if (m0_if.pready === 1'b1 && m1_if.pready === 1'b1) begin
        miscompares++;
        $display("FAIL sb_both_ready: got m0=1 m1=1, want one-hot");
      end else if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pready m0=%b m1=%b, want none", m0_if.pready, m1_if.pready);
      end else begin
        e       = sbq.pop_front();
        am      = m1_if.pready;
        got_rd  = am ? m1_if.prdata  : m0_if.prdata;
        oth_rd  = am ? m0_if.prdata  : m1_if.prdata;
        got_err = am ? m1_if.pslverr : m0_if.pslverr;
        oth_err = am ? m0_if.pslverr : m1_if.pslverr;
        vectors++;
        if (am !== e.mst) begin miscompares++;
          $display("FAIL sb_master: got %0d, want %0d", am, e.mst); end
        vectors++;
        if (got_rd !== e.rdata) begin miscompares++;
          $display("FAIL sb_prdata: got %h, want %h", got_rd, e.rdata); end
        vectors++;
        if (got_err !== e.err) begin miscompares++;
          $display("FAIL sb_pslverr: got %b, want %b", got_err, e.err); end
        vectors++;
        if (oth_rd !== '0 || oth_err !== 1'b0) begin miscompares++;
          $display("FAIL sb_other_master: got prdata %h pslverr %b, want 0 0", oth_rd, oth_err); end
        vectors++;
        if (s_if.paddr !== e.addr) begin miscompares++;
          $display("FAIL sb_paddr: got %h, want %h", s_if.paddr, e.addr); end
        vectors++;
        if (s_if.pwrite !== e.wr) begin miscompares++;
          $display("FAIL sb_pwrite: got %b, want %b", s_if.pwrite, e.wr); end
        if (e.wr) begin
          vectors++;
          if (s_if.pwdata !== e.wdata) begin miscompares++;
            $display("FAIL sb_pwdata: got %h, want %h", s_if.pwdata, e.wdata); end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_if.psel = 1'b0; m1_if.psel = 1'b0;
    slv_wait = 1; slv_stale = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Lets masters drop psel after their completion until the scoreboard drains.
  task automatic drain(input int max_cyc);
    logic p0, p1;
    for (int c = 0; c < max_cyc && sbq.size() != 0; c++) begin
      @(negedge clk);
      p0 = m0_if.pready; p1 = m1_if.pready;
      cyc();
      if (p0 === 1'b1) m0_if.psel = 1'b0;
      if (p1 === 1'b1) m1_if.psel = 1'b0;
    end
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d outstanding, want 0", sbq.size());
      sbq.delete();
    end
    m0_if.psel = 1'b0; m1_if.psel = 1'b0;
  endtask

  task automatic m0_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_if.psel = 1'b1; m0_if.pwrite = wr; m0_if.paddr = a; m0_if.pwdata = d;
  endtask

  task automatic m1_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_if.psel = 1'b1; m1_if.pwrite = wr; m1_if.paddr = a; m1_if.pwdata = d;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if (s_if.psel !== 1'b0 || s_if.penable !== 1'b0) begin miscompares++;
      $display("FAIL rst_slave_strobes: got psel %b penable %b, want 0 0", s_if.psel, s_if.penable); end
    vectors++;
    if (m0_if.pready !== 1'b0 || m0_if.pslverr !== 1'b0 || m0_if.prdata !== '0) begin miscompares++;
      $display("FAIL rst_m0_outputs: got %b %b %h, want 0 0 0", m0_if.pready, m0_if.pslverr, m0_if.prdata); end
    vectors++;
    if (m1_if.pready !== 1'b0 || m1_if.pslverr !== 1'b0 || m1_if.prdata !== '0) begin miscompares++;
      $display("FAIL rst_m1_outputs: got %b %b %h, want 0 0 0", m1_if.pready, m1_if.pslverr, m1_if.prdata); end
    vectors++;
    if (gnt !== 1'b1) begin miscompares++;
      $display("FAIL rst_gnt: got %b, want 1", gnt); end
  endtask

  task automatic test_single_write();
    do_reset();
    slv_rdata = 32'h0BAD_F00D;
    cyc();                                    // cycle 0
    m0_req(1'b1, 16'd2, 32'h0000_0100);
    sbq.push_back('{1'b0, 32'h0BAD_F00D, 1'b0, 16'd2, 1'b1, 32'h0000_0100});
    @(negedge clk);
    vectors++;
    if (s_if.psel !== 1'b0) begin miscompares++;
      $display("FAIL sw_c0_psel: got %b, want 0", s_if.psel); end
    cyc(); @(negedge clk);                    // cycle 1
    vectors++;
    if (s_if.psel !== 1'b1 || s_if.penable !== 1'b0) begin miscompares++;
      $display("FAIL sw_c1_setup: got psel %b penable %b, want 1 0", s_if.psel, s_if.penable); end
    vectors++;
    if (s_if.paddr !== 16'd2 || s_if.pwdata !== 32'h100 || s_if.pwrite !== 1'b1) begin miscompares++;
      $display("FAIL sw_c1_payload: got %h %h %b, want 0002 00000100 1", s_if.paddr, s_if.pwdata, s_if.pwrite); end
    cyc(); @(negedge clk);                    // cycle 2
    vectors++;
    if (s_if.penable !== 1'b1 || m0_if.pready !== 1'b0) begin miscompares++;
      $display("FAIL sw_c2_access: got penable %b m0_pready %b, want 1 0", s_if.penable, m0_if.pready); end
    cyc(); @(negedge clk);                    // cycle 3
    vectors++;
    if (m0_if.pready !== 1'b1 || m1_if.pready !== 1'b0) begin miscompares++;
      $display("FAIL sw_c3_pready: got m0 %b m1 %b, want 1 0", m0_if.pready, m1_if.pready); end
    cyc(); m0_if.psel = 1'b0; @(negedge clk); // cycle 4
    vectors++;
    if (s_if.psel !== 1'b0 || m0_if.pready !== 1'b0 || gnt !== 1'b0) begin miscompares++;
      $display("FAIL sw_c4_idle: got psel %b m0_pready %b gnt %b, want 0 0 0", s_if.psel, m0_if.pready, gnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    slv_rdata = 32'h0000_0042;
    cyc();                                    // cycle 0
    m0_req(1'b1, 16'd4, 32'hAAAA_0004);
    m1_req(1'b0, 16'd5, 32'h5555_0005);
    sbq.push_back('{1'b0, 32'h42, 1'b0, 16'd4, 1'b1, 32'hAAAA_0004});
    sbq.push_back('{1'b1, 32'h42, 1'b0, 16'd5, 1'b0, 32'h5555_0005});
    cyc(); cyc(); cyc(); @(negedge clk);      // cycle 3
    vectors++;
    if (m0_if.pready !== 1'b1 || m1_if.pready !== 1'b0) begin miscompares++;
      $display("FAIL b2b_c3_pready: got m0 %b m1 %b, want 1 0", m0_if.pready, m1_if.pready); end
    cyc(); m0_if.psel = 1'b0; @(negedge clk); // cycle 4
    vectors++;
    if (s_if.psel !== 1'b1 || s_if.penable !== 1'b0 || gnt !== 1'b1) begin miscompares++;
      $display("FAIL b2b_c4_setup: got psel %b penable %b gnt %b, want 1 0 1", s_if.psel, s_if.penable, gnt); end
    cyc(); @(negedge clk);                    // cycle 5
    vectors++;
    if (m1_if.pready !== 1'b0 || s_if.penable !== 1'b1) begin miscompares++;
      $display("FAIL b2b_c5_access: got m1_pready %b penable %b, want 0 1", m1_if.pready, s_if.penable); end
    cyc(); @(negedge clk);                    // cycle 6
    vectors++;
    if (m1_if.pready !== 1'b1 || m0_if.pready !== 1'b0) begin miscompares++;
      $display("FAIL b2b_c6_pready: got m1 %b m0 %b, want 1 0", m1_if.pready, m0_if.pready); end
    cyc(); m1_if.psel = 1'b0; @(negedge clk); // cycle 7
    vectors++;
    if (s_if.psel !== 1'b0) begin miscompares++;
      $display("FAIL b2b_c7_idle: got psel %b, want 0", s_if.psel); end
    cyc();                                    // cycle 8: alternation
    m0_req(1'b0, 16'd8, 32'h0);
    m1_req(1'b0, 16'd9, 32'h0);
    sbq.push_back('{1'b0, 32'h42, 1'b0, 16'd8, 1'b0, 32'h0});
    sbq.push_back('{1'b1, 32'h42, 1'b0, 16'd9, 1'b0, 32'h0});
    cyc(); @(negedge clk);                    // cycle 9
    vectors++;
    if (gnt !== 1'b0 || s_if.paddr !== 16'd8) begin miscompares++;
      $display("FAIL b2b_alternate: got gnt %b paddr %h, want 0 0008", gnt, s_if.paddr); end
    drain(20);
  endtask

  task automatic test_read_routing();
    do_reset();
    slv_rdata = 32'h1234_5678;
    cyc();
    m1_req(1'b0, 16'd3, 32'h0);
    sbq.push_back('{1'b1, 32'h1234_5678, 1'b0, 16'd3, 1'b0, 32'h0});
    drain(20);
  endtask

  task automatic test_stale_pready();
    do_reset();
    slv_stale = 1'b1;
    slv_rdata = 32'h0000_7777;
    cyc();                                    // cycle 0
    m0_req(1'b1, 16'd10, 32'h1010_1010);
    m1_req(1'b0, 16'd11, 32'h0);
    sbq.push_back('{1'b0, 32'h7777, 1'b0, 16'd10, 1'b1, 32'h1010_1010});
    sbq.push_back('{1'b1, 32'h7777, 1'b0, 16'd11, 1'b0, 32'h0});
    cyc(); cyc(); cyc(); @(negedge clk);      // cycle 3
    vectors++;
    if (m0_if.pready !== 1'b1) begin miscompares++;
      $display("FAIL stale_c3_m0: got %b, want 1", m0_if.pready); end
    cyc(); m0_if.psel = 1'b0; @(negedge clk); // cycle 4: SETUP with stale ready
    vectors++;
    if (m0_if.pready !== 1'b0 || m1_if.pready !== 1'b0) begin miscompares++;
      $display("FAIL stale_c4_setup: got m0 %b m1 %b, want 0 0", m0_if.pready, m1_if.pready); end
    drain(20);
    slv_stale = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    slv_wait  = 255;
    slv_rdata = 32'hCAFE_F00D;
    cyc();                                    // cycle 0
    m0_req(1'b0, 16'd6, 32'h0);
    sbq.push_back('{1'b0, 32'h0, 1'b1, 16'd6, 1'b0, 32'h0});
    cyc(); cyc(); cyc(); cyc(); @(negedge clk); // cycle 4: 3rd ACCESS cycle
    vectors++;
    if (m0_if.pready !== 1'b0) begin miscompares++;
      $display("FAIL tmo_early: got m0_pready %b, want 0", m0_if.pready); end
    cyc(); @(negedge clk);                    // cycle 5: 4th ACCESS cycle
    vectors++;
    if (m0_if.pready !== 1'b1 || m0_if.pslverr !== 1'b1 || m0_if.prdata !== '0) begin miscompares++;
      $display("FAIL tmo_fire: got %b %b %h, want 1 1 00000000", m0_if.pready, m0_if.pslverr, m0_if.prdata); end
    cyc(); m0_if.psel = 1'b0; @(negedge clk); // cycle 6
    vectors++;
    if (s_if.psel !== 1'b0 || m0_if.pready !== 1'b0) begin miscompares++;
      $display("FAIL tmo_idle: got psel %b m0_pready %b, want 0 0", s_if.psel, m0_if.pready); end
    slv_wait = 3;                             // ready on the 4th ACCESS cycle
    cyc();
    m0_req(1'b0, 16'd6, 32'h0);
    sbq.push_back('{1'b0, 32'hCAFE_F00D, 1'b0, 16'd6, 1'b0, 32'h0});
    drain(20);
    slv_wait = 1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    slv_wait  = 1;
    slv_rdata = 32'h5555_AAAA;
    cyc();                                    // cycle 0
    m0_req(1'b0, 16'd7, 32'h0);
    cyc(); cyc();                             // cycle 2: ACCESS
    cyc();                                    // cycle 3: slave ready + rst
    rst = 1'b1; m0_if.psel = 1'b0;
    @(negedge clk);
    vectors++;
    if (m0_if.pready !== 1'b0 || m1_if.pready !== 1'b0 || m0_if.prdata !== '0) begin miscompares++;
      $display("FAIL rmid_during: got m0 %b m1 %b prdata %h, want 0 0 0", m0_if.pready, m1_if.pready, m0_if.prdata); end
    cyc(); rst = 1'b0; @(negedge clk);       // cycle 4
    vectors++;
    if (s_if.psel !== 1'b0 || s_if.penable !== 1'b0 || m0_if.pready !== 1'b0 || gnt !== 1'b1) begin miscompares++;
      $display("FAIL rmid_after: got psel %b penable %b m0_pready %b gnt %b, want 0 0 0 1",
               s_if.psel, s_if.penable, m0_if.pready, gnt); end
    cyc();                                    // cycle 5
    m1_req(1'b0, 16'd9, 32'h0);
    sbq.push_back('{1'b1, 32'h5555_AAAA, 1'b0, 16'd9, 1'b0, 32'h0});
    cyc(); @(negedge clk);                    // cycle 6: SETUP
    vectors++;
    if (s_if.psel !== 1'b1 || gnt !== 1'b1) begin miscompares++;
      $display("FAIL rmid_regrant: got psel %b gnt %b, want 1 1", s_if.psel, gnt); end
    drain(20);
  endtask

  initial begin
    rst = 1'b1;
    m0_if.psel = 1'b0; m0_if.penable = 1'b0; m0_if.pwrite = 1'b0; m0_if.paddr = '0; m0_if.pwdata = '0;
    m1_if.psel = 1'b0; m1_if.penable = 1'b0; m1_if.pwrite = 1'b0; m1_if.paddr = '0; m1_if.pwdata = '0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_routing();
    test_stale_pready();
    test_timeout();
    test_reset_mid();
    cyc(); cyc();
    vectors++;
    if (sbq.size() != 0) begin miscompares++;
      $display("FAIL final_queue: got %0d outstanding, want 0", sbq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/apb_arbiter2.md
Name: apb_arbiter2

Overview:
- Two-master, one-slave APB arbiter. Shares a single APB slave (e.g. the timer block) between two requesters, such as a CPU bridge and a DMA/sequencer.
- Round-robin grant. The arbiter generates its own slave-side SETUP/ACCESS phases.
- Forwards the slave's pready and prdata back to the granted master only.
- An optional watchdog terminates a transfer when the slave never answers.

Parameters:
- AW, 16, address width
- DW, 32, data width
- TIMEOUT, 0, ACCESS-phase cycles before forced error completion; 0 = disabled
- TW, 8, timeout counter width; TIMEOUT < 2^TW

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- m0_psel  in  1  master 0 select (request)
- m0_penable  in  1  master 0 enable (ignored for arbitration)
- m0_pwrite  in  1  master 0 write
- m0_paddr  in  AW  master 0 address
- m0_pwdata  in  DW  master 0 write data
- m0_prdata  out  DW  master 0 read data
- m0_pready  out  1  master 0 transfer complete
- m0_pslverr  out  1  master 0 timeout error
- m1_*  same set as m0_*  master 1
- s_psel  out  1  slave select
- s_penable  out  1  slave enable
- s_pwrite  out  1  slave write
- s_paddr  out  AW  slave address
- s_pwdata  out  DW  slave write data
- s_prdata  in  DW  slave read data
- s_pready  in  1  slave ready
- gnt  out  1  currently/last granted master index (debug)

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- State machine, states IDLE, SETUP, ACCESS:
  - s_psel = (state != IDLE), taken from a registered state.
  - s_penable = (state == ACCESS).
- Reset (also mid-transfer): state = IDLE, gnt = 1 so master 0 wins first, timeout counter = 0. All s_psel/s_penable/m*_pready/m*_pslverr = 0, and all m*_prdata = 0. An in-flight slave transfer is abandoned; no pready goes to either master.
- IDLE:
  - Only m0 requests (m0_psel = 1) -> gnt = 0, go to SETUP.
  - Only m1 requests -> gnt = 1, go to SETUP.
  - Both request -> grant the master != gnt, go to SETUP.
  - Neither requests -> stay in IDLE.
- SETUP: always go to ACCESS next cycle. s_pready is ignored in SETUP, because the slave may still show a stale pready from the previous transfer.
- ACCESS, completion when s_pready = 1:
  - m{gnt}_pready = 1 and m{gnt}_prdata = s_prdata in the same cycle (combinational pass).
  - The other master's outputs stay 0.
  - Next state: if the other master's psel = 1, grant it and go directly to SETUP (back-to-back). Otherwise go to IDLE.
  - The just-served master's psel is never evaluated in its own completion cycle; it must drop psel next cycle.
- ACCESS, timeout when TIMEOUT > 0:
  - The counter increments each ACCESS cycle without s_pready and clears on leaving ACCESS.
  - When it reaches TIMEOUT: m{gnt}_pready = 1, m{gnt}_pslverr = 1, m{gnt}_prdata = 0, then take the same next-state choice as a normal completion.
  - If s_pready and the timeout coincide, s_pready wins and pslverr = 0.
- Muxing: s_pwrite, s_paddr and s_pwdata follow the gnt master combinationally in every state; in IDLE they show the last grant.
- Pass-through: a master not granted sees pready = 0 and waits with psel held.
- Master drops psel before completion (protocol violation): the slave transfer still runs to completion or timeout. The completion pulse is still driven; no recovery action is taken.
- Latency: request seen in IDLE at cycle N -> s_psel at N+1 and s_penable at N+2. With a 1-wait registered-pready slave, m_pready is at N+3.
- Throughput: alternating requesters run at 3 cycles per transfer with no IDLE gap.

Test Plan:
- Single write: m0 writes paddr = 2, pwdata = 0x0000_0100 at cycle 0; slave raises pready at cycle 3 -> s_psel at 1, s_penable at 2, s_paddr = 2, s_pwdata = 0x100, m0_pready = 1 at cycle 3 only, m1 outputs all 0.
- Simultaneous requests after reset: m0 and m1 both raise psel at cycle 0 -> m0 is served first (pready at cycle 3). m1 gets SETUP at cycle 4 with no IDLE gap and m1_pready at cycle 6. The next simultaneous request is granted to m0 (alternation).
- Read data routing: m1 reads paddr = 3 and the slave returns prdata = 0x1234_5678 with pready -> m1_prdata = 0x1234_5678 in the pready cycle, m0_prdata = 0.
- Stale pready: the slave holds pready high one extra cycle after completion while the next grant is in SETUP -> no pready is forwarded to any master until the next ACCESS-phase pready.
- Timeout, TIMEOUT = 4: the slave never asserts pready -> m0_pready = 1 and m0_pslverr = 1 with m0_prdata = 0 after 4 ACCESS cycles, then the arbiter returns to IDLE. Repeat with s_pready arriving on the 4th cycle -> pslverr = 0.
- Reset mid-ACCESS: assert rst for 1 cycle during ACCESS -> the next cycle shows s_psel = 0 and no m*_pready. A fresh m1-only request afterwards is granted normally.
